hop_const_ser_tx: RTL

Bit-serial transmitter for the HOP constant. It accepts a parallel HOP word from the processor side over a valid/ready handshake and shifts it out LSB-first, one bit per bit-time strobe, aligned to the word sync. An optional odd-parity bit follows the data bits. It is the sending end of the serial HOP path whose receiving side decodes module/sector selects and HOPC1 in the memory module register section.

---
 rtl/hop_pkg.sv | 35 +++
 rtl/hop_bit_timer.sv | 43 ++++
 rtl/hop_const_ser_tx.sv | 133 +++++++++++++
 3 files changed

// File: rtl/hop_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hop_pkg
// Brief    : Shared HOP word layout and transmitter state encoding.
// Revision : 1.0
// ============================================================================
package hop_pkg;

    localparam int HOP_W = 26;

    // Field positions within the HOP word (LSB index, width)
    localparam int HOP_IA_LSB   = 0;
    localparam int HOP_IA_W     = 14;
    localparam int HOP_IS_LSB   = 14;
    localparam int HOP_IS_W     = 2;
    localparam int HOP_SYL_LSB  = 16;
    localparam int HOP_SYL_W    = 2;
    localparam int HOP_IM_LSB   = 18;
    localparam int HOP_IM_W     = 2;
    localparam int HOP_DS_LSB   = 20;
    localparam int HOP_DS_W     = 2;
    localparam int HOP_DM_LSB   = 22;
    localparam int HOP_DM_W     = 2;
    localparam int HOP_DUPI_BIT = 24;
    localparam int HOP_DUPD_BIT = 25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_SHIFT = 2'd2,
        ST_PAR   = 2'd3
    } hop_state_e;

endpackage
`default_nettype wire

// File: rtl/hop_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : hop_bit_timer
// Brief    : Qualifies bit strobes / word sync and counts emitted data bits.
// Revision : 1.0
// ============================================================================
module hop_bit_timer #(
    parameter int WORD_W = 26
) (
    input  logic CLK,
    input  logic RSTN,
    input  logic BIT_STB,
    input  logic SYNC,
    input  logic clr_i,
    input  logic start_i,
    input  logic adv_i,
    output logic stb_o,
    output logic sync_stb_o,
    output logic last_o
);
    localparam int                CNT_W    = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_W);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            count_q <= '0;
        end else if (clr_i) begin
            count_q <= '0;
        end else if (start_i) begin
            count_q <= CNT_W'(1);
        end else if (adv_i) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign stb_o      = BIT_STB;
    assign sync_stb_o = BIT_STB & SYNC;
    assign last_o     = (count_q == LAST_CNT);

endmodule
`default_nettype wire

// File: rtl/hop_const_ser_tx.sv
`default_nettype none
// ============================================================================
// Module   : hop_const_ser_tx
// Brief    : LSB-first serial transmitter for the HOP word with odd parity.
// Revision : 1.0
// ============================================================================
module hop_const_ser_tx
    import hop_pkg::*;
#(
    parameter int WORD_W    = HOP_W,
    parameter bit PARITY_EN = 1'b1
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic [WORD_W-1:0] HOP_IN,
    input  logic              HOP_VALID,
    output logic              HOP_READY,
    input  logic              BIT_STB,
    input  logic              SYNC,
    output logic              HOPS,
    output logic              HOPV,
    output logic              DONE,
    output logic              SYNC_ERR
);
    hop_state_e        state_q;
    logic [WORD_W-1:0] sreg_q;
    logic              par_q;
    logic              ready_q;
    logic              hops_q;
    logic              hopv_q;
    logic              done_q;
    logic              serr_q;

    logic w_stb;
    logic w_sync_stb;
    logic w_last;
    logic w_accept;
    logic w_start;
    logic w_adv;

    assign w_accept = (state_q == ST_IDLE) && ready_q && HOP_VALID;
    assign w_start  = (state_q == ST_ARMED) && w_sync_stb;
    assign w_adv    = (state_q == ST_SHIFT) && w_stb && !w_last;

    hop_bit_timer #(
        .WORD_W (WORD_W)
    ) u_timer (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .BIT_STB    (BIT_STB),
        .SYNC       (SYNC),
        .clr_i      (w_accept),
        .start_i    (w_start),
        .adv_i      (w_adv),
        .stb_o      (w_stb),
        .sync_stb_o (w_sync_stb),
        .last_o     (w_last)
    );

    // The shift register moves right after each emitted bit, so sreg_q[0]
    // is always the next data bit to put on the wire.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= ST_IDLE;
            sreg_q  <= '0;
            par_q   <= 1'b0;
            ready_q <= 1'b1;
            hops_q  <= 1'b0;
            hopv_q  <= 1'b0;
            done_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        sreg_q  <= HOP_IN;
                        par_q   <= ~^HOP_IN;
                        serr_q  <= 1'b0;
                        ready_q <= 1'b0;
                        state_q <= ST_ARMED;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_sync_stb) begin
                        hops_q  <= sreg_q[0];
                        hopv_q  <= 1'b1;
                        sreg_q  <= sreg_q >> 1;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_stb) begin
                        if (!w_last) begin
                            hops_q <= sreg_q[0];
                            sreg_q <= sreg_q >> 1;
                            if (w_sync_stb) begin
                                serr_q <= 1'b1;
                            end
                        end else if (PARITY_EN) begin
                            hops_q  <= par_q;
                            state_q <= ST_PAR;
                        end else begin
                            hops_q  <= 1'b0;
                            hopv_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_PAR: begin
                    if (w_stb) begin
                        hops_q  <= 1'b0;
                        hopv_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign HOP_READY = ready_q;
    assign HOPS      = hops_q;
    assign HOPV      = hopv_q;
    assign DONE      = done_q;
    assign SYNC_ERR  = serr_q;

endmodule
`default_nettype wire
